// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its front-end scheduler.
package instr_register_pkg;

    typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  result;
    } instruction_t;

    typedef enum logic [1:0] {RST_HOLD, RUN, FLUSH} sched_state_t;

    localparam int QDEPTH = 32;

    // DIV/MOD by zero must never reach the register's ALU.
    function automatic logic is_divzero(input opcode_t opc, input operand_t op_b);
        return ((opc == DIV) || (opc == MOD)) && (op_b == '0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester after the last one served.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [LW-1:0] rr_last;
    logic [LW-1:0] grant_idx;
    logic [LW-1:0] cand;

    // Walk from farthest to nearest so the nearest active requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = rr_last;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = LW'((int'(rr_last) + k) % NREQ);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= LW'(NREQ - 1);
        end else if (advance && (|grant)) begin
            rr_last <= grant_idx;
        end
    end

endmodule

// File: rtl/instr_reg_scheduler.sv
// Front-end for the 32-entry instruction register: arbitrated writes, in-order
// reads as a circular queue, reset sequencing and divide-by-zero sanitising.
module instr_reg_scheduler
    import instr_register_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int DEPTH      = QDEPTH,
    parameter int RST_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [NREQ-1:0]        req_valid,
    input  opcode_t [NREQ-1:0]     req_opcode,
    input  operand_t [NREQ-1:0]    req_op_a,
    input  operand_t [NREQ-1:0]    req_op_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output instruction_t           out_instr,
    output logic                   reg_load_en,
    output logic                   reg_reset_n,
    output opcode_t                reg_opcode,
    output operand_t               reg_operand_a,
    output operand_t               reg_operand_b,
    output address_t               reg_write_pointer,
    output address_t               reg_read_pointer,
    input  instruction_t           reg_instr_word,
    output logic [$clog2(DEPTH):0] count,
    output logic                   divzero_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int HW = $clog2(RST_CYCLES) + 1;

    sched_state_t    state;
    logic [HW-1:0]   hold_cnt;
    address_t        wr_ptr;
    address_t        rd_ptr;

    logic            run;
    logic            full;
    logic            push;
    logic            pop;
    logic            divzero;
    logic [NREQ-1:0] grant;
    opcode_t         sel_opc;
    operand_t        sel_a;
    operand_t        sel_b;

    assign run  = (state == RUN);
    assign full = (count == CW'(DEPTH));

    // Flush suppresses grants combinationally so nothing is pushed on the flush edge.
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid & {NREQ{run && !full && !flush}}),
        .advance (push),
        .grant   (grant)
    );

    assign req_ready   = grant;
    assign push        = |(req_valid & grant);
    assign reg_load_en = push;

    always_comb begin
        sel_opc = ZERO;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_opc = req_opcode[i];
                sel_a   = req_op_a[i];
                sel_b   = req_op_b[i];
            end
        end
    end

    assign divzero           = push && is_divzero(sel_opc, sel_b);
    assign reg_opcode        = is_divzero(sel_opc, sel_b) ? ZERO : sel_opc;
    assign reg_operand_a     = sel_a;
    assign reg_operand_b     = sel_b;
    assign reg_write_pointer = wr_ptr;
    assign reg_read_pointer  = rd_ptr;

    assign out_valid = run && !flush && (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_instr = reg_instr_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RST_HOLD;
            hold_cnt    <= '0;
            reg_reset_n <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            divzero_err <= 1'b0;
        end else begin
            case (state)
                RST_HOLD, FLUSH: begin
                    if (hold_cnt == HW'(RST_CYCLES - 1)) begin
                        state       <= RUN;
                        reg_reset_n <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state       <= FLUSH;
                        hold_cnt    <= '0;
                        reg_reset_n <= 1'b0;
                    end
                end
                default: state <= RST_HOLD;
            endcase

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end

            if (divzero) divzero_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_reg_scheduler.sv
// Directed bench for instr_reg_scheduler with a behavioural instruction register attached.
module tb_instr_reg_scheduler;
    import instr_register_pkg::*;

    localparam int NREQ = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                flush;
    logic [NREQ-1:0]     req_valid;
    opcode_t [NREQ-1:0]  req_opcode;
    operand_t [NREQ-1:0] req_op_a;
    operand_t [NREQ-1:0] req_op_b;
    logic [NREQ-1:0]     req_ready;
    logic                out_valid;
    logic                out_ready;
    instruction_t        out_instr;
    logic                reg_load_en;
    logic                reg_reset_n;
    opcode_t             reg_opcode;
    operand_t            reg_operand_a;
    operand_t            reg_operand_b;
    address_t            reg_write_pointer;
    address_t            reg_read_pointer;
    instruction_t        reg_instr_word;
    logic [5:0]          count;
    logic                divzero_err;

    int checks   = 0;
    int failures = 0;

    instruction_t iw_reg [32];

    instr_reg_scheduler #(.NREQ(NREQ), .DEPTH(32), .RST_CYCLES(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .req_valid         (req_valid),
        .req_opcode        (req_opcode),
        .req_op_a          (req_op_a),
        .req_op_b          (req_op_b),
        .req_ready         (req_ready),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_instr         (out_instr),
        .reg_load_en       (reg_load_en),
        .reg_reset_n       (reg_reset_n),
        .reg_opcode        (reg_opcode),
        .reg_operand_a     (reg_operand_a),
        .reg_operand_b     (reg_operand_b),
        .reg_write_pointer (reg_write_pointer),
        .reg_read_pointer  (reg_read_pointer),
        .reg_instr_word    (reg_instr_word),
        .count             (count),
        .divzero_err       (divzero_err)
    );

    always #5 clk = ~clk;

    function automatic result_t calc(input opcode_t o, input operand_t a, input operand_t b);
        case (o)
            PASSA:   return result_t'(a);
            PASSB:   return result_t'(b);
            ADD:     return result_t'(a) + result_t'(b);
            SUB:     return result_t'(a) - result_t'(b);
            MULT:    return result_t'(a) * result_t'(b);
            DIV:     return (b == 0) ? '0 : result_t'(a / b);
            MOD:     return (b == 0) ? '0 : result_t'(a % b);
            default: return '0;
        endcase
    endfunction

    // Stand-in for the instruction register the scheduler drives.
    always @(posedge clk) begin
        if (!reg_reset_n) begin
            for (int i = 0; i < 32; i++) iw_reg[i] <= '0;
        end else if (reg_load_en) begin
            iw_reg[reg_write_pointer] <= '{opc: reg_opcode, op_a: reg_operand_a, op_b: reg_operand_b,
                                          result: calc(reg_opcode, reg_operand_a, reg_operand_b)};
        end
    end

    assign reg_instr_word = iw_reg[reg_read_pointer];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        step();
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        req_valid     = 2'b11;
        out_ready     = 1'b1;
        req_opcode[0] = ADD;
        req_opcode[1] = ADD;
        req_op_a      = '0;
        req_op_b      = '0;

        // Reset: nothing granted, register held in reset
        repeat (3) step();
        chk("rst_reset_n", 64'(reg_reset_n), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_load_en", 64'(reg_load_en), 64'd0);
        chk("rst_divzero", 64'(divzero_err), 64'd0);
        req_valid = '0;
        out_ready = 1'b0;
        reset     = 1'b0;
        step();
        chk("hold_reset_n", 64'(reg_reset_n), 64'd0);
        step();
        chk("run_reset_n", 64'(reg_reset_n), 64'd1);

        // Single push from req0, then read back one cycle later
        req_opcode[0] = ADD;
        req_op_a[0]   = 5;
        req_op_b[0]   = 7;
        req_valid     = 2'b01;
        #1;
        chk("a_ready", 64'(req_ready), 64'd1);
        chk("a_load_en", 64'(reg_load_en), 64'd1);
        chk("a_wr_ptr", 64'(reg_write_pointer), 64'd0);
        step();
        req_valid = '0;
        #1;
        chk("a_load_off", 64'(reg_load_en), 64'd0);
        chk("a_count", 64'(count), 64'd1);
        chk("a_out_valid", 64'(out_valid), 64'd1);
        chk("a_opc", 64'(out_instr.opc), 64'(ADD));
        chk("a_result", 64'(out_instr.result), 64'd12);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        chk("a_pop_count", 64'(count), 64'd0);
        chk("a_pop_valid", 64'(out_valid), 64'd0);

        // Req1 alone lands at the next slot
        req_opcode[1] = SUB;
        req_op_a[1]   = 20;
        req_op_b[1]   = 3;
        req_valid     = 2'b10;
        #1;
        chk("r1_ready", 64'(req_ready), 64'd2);
        chk("r1_wr_ptr", 64'(reg_write_pointer), 64'd1);
        step();
        req_valid = '0;
        out_ready = 1'b1;
        #1;
        chk("r1_result", 64'(out_instr.result), 64'd17);
        step();
        out_ready = 1'b0;

        // Both requesting: grants alternate starting with req0
        req_opcode[0] = ADD;
        req_op_a[0]   = 1;
        req_op_b[0]   = 1;
        req_opcode[1] = ADD;
        req_op_a[1]   = 2;
        req_op_b[1]   = 2;
        req_valid     = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("b_grant", 64'(req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
            step();
        end
        req_valid = '0;
        #1;
        chk("b_count", 64'(count), 64'd4);
        chk("b_head", 64'(out_instr.result), 64'd2);

        // Fill to DEPTH with no consumer
        do_reset();
        req_opcode[0] = ADD;
        req_op_b[0]   = 100;
        req_valid     = 2'b01;
        for (int i = 0; i < 32; i++) begin
            req_op_a[0] = operand_t'(i);
            step();
        end
        chk("full_count", 64'(count), 64'd32);
        chk("full_ready", 64'(req_ready), 64'd0);
        chk("full_load", 64'(reg_load_en), 64'd0);
        chk("full_head", 64'(out_instr.result), 64'd100);
        req_op_a[0] = 77;
        out_ready   = 1'b1;
        #1;
        chk("full_pop_ready", 64'(req_ready), 64'd0);
        step();
        out_ready = 1'b0;
        #1;
        chk("pop_count", 64'(count), 64'd31);
        chk("pop_head", 64'(out_instr.result), 64'd101);
        chk("wrap_ready", 64'(req_ready), 64'd1);
        chk("wrap_wr_ptr", 64'(reg_write_pointer), 64'd0);
        step();
        req_valid = '0;
        #1;
        chk("wrap_count", 64'(count), 64'd32);

        // Divide by zero is sanitised and flagged
        do_reset();
        chk("dz_clear", 64'(divzero_err), 64'd0);
        req_opcode[0] = DIV;
        req_op_a[0]   = 9;
        req_op_b[0]   = 0;
        req_valid     = 2'b01;
        #1;
        chk("dz_opcode", 64'(reg_opcode), 64'(ZERO));
        chk("dz_load", 64'(reg_load_en), 64'd1);
        step();
        chk("dz_err", 64'(divzero_err), 64'd1);
        chk("dz_stored_opc", 64'(out_instr.opc), 64'(ZERO));
        chk("dz_stored_res", 64'(out_instr.result), 64'd0);
        req_op_b[0] = 3;
        #1;
        chk("div_opcode", 64'(reg_opcode), 64'(DIV));
        repeat (4) step();
        chk("q5_count", 64'(count), 64'd5);

        // Flush with 5 queued; push and pop requests are ignored that cycle
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("fl_ready", 64'(req_ready), 64'd0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_load", 64'(reg_load_en), 64'd0);
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_reset_n0", 64'(reg_reset_n), 64'd0);
        chk("fl_dz_kept", 64'(divzero_err), 64'd1);
        step();
        chk("fl_reset_n1", 64'(reg_reset_n), 64'd0);
        chk("fl_hold_ready", 64'(req_ready), 64'd0);
        step();
        chk("fl_run_reset_n", 64'(reg_reset_n), 64'd1);
        chk("fl_run_ready", 64'(req_ready), 64'd1);
        chk("fl_wr_ptr", 64'(reg_write_pointer), 64'd0);
        step();
        req_valid = '0;
        #1;
        chk("fl_new_count", 64'(count), 64'd1);
        chk("fl_new_result", 64'(out_instr.result), 64'd3);

        do_reset();
        chk("dz_reset", 64'(divzero_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
